// File: rtl/alu_pkg.sv
// Shared ALU control codes and execution-unit state encoding.
// The codes are also consumed by the ALU control decoder.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0100;
    localparam logic [3:0] ALU_SRA = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_t;

endpackage

// File: rtl/alu_shifter_iter.sv
// Iterative one-bit-per-cycle shifter. The first step happens on the start
// cycle itself, so a shift by N asserts 'last' on its N-th step.
module alu_shifter_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int SHW = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [SHW-1:0]  amt,
    output logic [XLEN-1:0] data_next,
    output logic            last
);

    logic [XLEN-1:0] work_reg;
    logic [SHW-1:0]  cnt_reg;
    logic [3:0]      op_reg;

    logic [XLEN-1:0] src;
    logic [3:0]      op_cur;
    logic [SHW-1:0]  cnt_cur;

    always_comb begin
        src     = start ? a   : work_reg;
        op_cur  = start ? op  : op_reg;
        cnt_cur = start ? amt : cnt_reg;
        last    = (cnt_cur == SHW'(1));
        // SRA keeps the sign bit in place, so replicating the current MSB
        // replicates the original a[XLEN-1] on every step.
        case (op_cur)
            ALU_SLL: data_next = {src[XLEN-2:0], 1'b0};
            ALU_SRA: data_next = {src[XLEN-1], src[XLEN-1:1]};
            default: data_next = {1'b0, src[XLEN-1:1]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            work_reg <= '0;
            cnt_reg  <= '0;
            op_reg   <= ALU_SLL;
        end else if (start) begin
            work_reg <= data_next;
            cnt_reg  <= amt - SHW'(1);
            op_reg   <= op;
        end else if (cnt_reg != '0) begin
            work_reg <= data_next;
            cnt_reg  <= cnt_reg - SHW'(1);
        end
    end

endmodule

// File: rtl/alu_exec.sv
// Multi-cycle ALU execute unit with valid/ready handshake on both sides.
// Define ALU_SHIFT_EN to build the iterative shifter; otherwise shifts are illegal.
module alu_exec
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int SHW = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    alu_state_t      state_reg, state_next;
    logic [XLEN-1:0] result_reg, result_next;
    logic            zero_reg, zero_next;
    logic            illegal_reg, illegal_next;

    logic [XLEN-1:0] alu_res;
    logic            alu_ill;

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (alu_ctrl)
            ALU_AND: alu_res = a & b;
            ALU_OR:  alu_res = a | b;
            ALU_ADD: alu_res = a + b;
            ALU_SUB: alu_res = a - b;
            ALU_SLT: alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
`ifdef ALU_SHIFT_EN
            // Only reached for a zero shift amount; non-zero shifts use the shifter.
            ALU_SLL, ALU_SRL, ALU_SRA: alu_res = a;
`endif
            default: alu_ill = 1'b1;
        endcase
    end

`ifdef ALU_SHIFT_EN
    logic [SHW-1:0]  shamt;
    logic            is_shift;
    logic            shift_start;
    logic            shift_last;
    logic [XLEN-1:0] shift_data;

    assign shamt       = b[SHW-1:0];
    assign is_shift    = (alu_ctrl == ALU_SLL) || (alu_ctrl == ALU_SRL) || (alu_ctrl == ALU_SRA);
    assign shift_start = (state_reg == IDLE) && in_valid && is_shift && (shamt != '0);

    alu_shifter_iter #(.XLEN(XLEN)) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .start     (shift_start),
        .op        (alu_ctrl),
        .a         (a),
        .amt       (shamt),
        .data_next (shift_data),
        .last      (shift_last)
    );
`endif

    always_comb begin
        state_next   = state_reg;
        result_next  = result_reg;
        zero_next    = zero_reg;
        illegal_next = illegal_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    state_next   = DONE;
                    result_next  = alu_res;
                    illegal_next = alu_ill;
`ifdef ALU_SHIFT_EN
                    if (shift_start) begin
                        result_next  = shift_data;
                        illegal_next = 1'b0;
                        if (!shift_last) state_next = SHIFT;
                    end
`endif
                    zero_next = (result_next == '0);
                end
            end
`ifdef ALU_SHIFT_EN
            SHIFT: begin
                if (shift_last) begin
                    state_next  = DONE;
                    result_next = shift_data;
                    zero_next   = (shift_data == '0);
                end
            end
`endif
            DONE: begin
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            result_reg  <= '0;
            zero_reg    <= 1'b0;
            illegal_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            result_reg  <= result_next;
            zero_reg    <= zero_next;
            illegal_reg <= illegal_next;
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign result    = result_reg;
    assign zero      = zero_reg;
    assign illegal   = illegal_reg;

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: driver queues expected responses at accept,
// monitor pops and compares when out_valid rises and checks hold stability.
`timescale 1ns/1ps
module tb_alu_exec;

    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [3:0]  alu_ctrl = 4'b0000;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        in_ready, out_valid, zero, illegal;
    logic [31:0] result;

    alu_exec #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        ill;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        cur;
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          txn = 0;
    int          rdy_mode = 0;
    bit          mon_en = 1'b0;
    bit          held = 1'b0;
    logic [31:0] held_res;
    logic        held_zero, held_ill;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Independent golden model using native shift operators.
    function automatic void model(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic il, output int lat);
        int n;
        n   = int'(y[4:0]);
        r   = '0;
        il  = 1'b0;
        lat = 1;
        case (c)
            4'b0000: r = x & y;
            4'b0001: r = x | y;
            4'b0010: r = x + y;
            4'b0110: r = x - y;
            4'b0111: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
`ifdef ALU_SHIFT_EN
            4'b0011: begin r = x << n; lat = (n == 0) ? 1 : n; end
            4'b0100: begin r = x >> n; lat = (n == 0) ? 1 : n; end
            4'b0101: begin r = $signed(x) >>> n; lat = (n == 0) ? 1 : n; end
`endif
            default: il = 1'b1;
        endcase
    endfunction

    // Monitor: owns out_ready and all response comparisons.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (out_valid) begin
                if (!held) begin
                    if (sb_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_out_valid: got result %h with empty scoreboard (cycle %0d)", result, cyc);
                    end else begin
                        cur = sb_q.pop_front();
                        txn++;
                        $display("txn %0d: result=%h zero=%b illegal=%b lat=%0d (exp %h/%b/%b/%0d)",
                                 txn, result, zero, illegal, cyc - cur.acc + 1,
                                 cur.res, cur.zero, cur.ill, cur.lat);
                        check("result", result, cur.res);
                        check("zero", zero, cur.zero);
                        check("illegal", illegal, cur.ill);
                        check("latency", cyc - cur.acc + 1, cur.lat);
                    end
                    held      = 1'b1;
                    held_res  = result;
                    held_zero = zero;
                    held_ill  = illegal;
                end else begin
                    check("hold_result", result, held_res);
                    check("hold_zero", zero, held_zero);
                    check("hold_illegal", illegal, held_ill);
                    check("in_ready_while_done", in_ready, 0);
                end
            end
            case (rdy_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (out_valid && out_ready) held = 1'b0;
        end else begin
            held      = 1'b0;
            out_ready = (rdy_mode == 1);
        end
    end

    task automatic issue(input logic [3:0] c, input logic [31:0] aa, input logic [31:0] bb,
                         input logic [31:0] er, input logic ei, input int el, input bit push);
        int   waitc;
        exp_t e;
        waitc = 0;
        @(negedge clk);
        in_valid = 1'b1;
        alu_ctrl = c;
        a        = aa;
        b        = bb;
        while (!in_ready && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, expected 1", waitc);
            in_valid = 1'b0;
            return;
        end
        if (push) begin
            e.res  = er;
            e.zero = (er == 32'd0);
            e.ill  = ei;
            e.lat  = el;
            e.acc  = cyc + 1;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        // Scramble inputs after accept; the DUT must ignore them.
        in_valid = 1'b0;
        alu_ctrl = 4'($urandom);
        a        = $urandom;
        b        = $urandom;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb_q.size() != 0 || held) && t < 500) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        check("drain_pending", sb_q.size(), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ra, rb, er;
        logic        ei;
        int          el;
        logic [3:0]  c;
        bit          seen;
        logic [3:0]  codes [16];

        codes = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                  4'h7, 4'h2, 4'h6, 4'h3, 4'h5, 4'h4, 4'h9, 4'hF};

        repeat (3) @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_result", result, 0);
        check("reset_zero", zero, 0);
        check("reset_illegal", illegal, 0);

        // ADD held under backpressure, then released.
        rdy_mode = 0;
        issue(4'b0010, 32'd5, 32'd7, 32'd12, 1'b0, 1, 1'b1);
        repeat (5) @(negedge clk);
        rdy_mode = 1;
        drain();

        issue(4'b0110, 32'd9, 32'd9, 32'd0, 1'b0, 1, 1'b1);
        issue(4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1, 1'b1);
        issue(4'b0111, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1, 1'b1);
        issue(4'b0000, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1'b0, 1, 1'b1);
        issue(4'b0001, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1'b0, 1, 1'b1);
        issue(4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1, 1'b1);
        issue(4'b0110, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1, 1'b1);
`ifdef ALU_SHIFT_EN
        issue(4'b0101, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 4, 1'b1);
        issue(4'b0011, 32'h1234_5678, 32'h0000_0100, 32'h1234_5678, 1'b0, 1, 1'b1);
        issue(4'b0011, 32'h0000_0001, 32'd1, 32'h0000_0002, 1'b0, 1, 1'b1);
        issue(4'b0100, 32'hF000_0000, 32'd31, 32'h0000_0001, 1'b0, 31, 1'b1);
        issue(4'b0101, 32'h4000_0000, 32'd30, 32'h0000_0001, 1'b0, 30, 1'b1);
`else
        issue(4'b0101, 32'h8000_0000, 32'd4, 32'd0, 1'b1, 1, 1'b1);
        issue(4'b0011, 32'h1234_5678, 32'h0000_0100, 32'd0, 1'b1, 1, 1'b1);
        issue(4'b0100, 32'hF000_0000, 32'd31, 32'd0, 1'b1, 1, 1'b1);
`endif
        issue(4'b1111, 32'd3, 32'd4, 32'd0, 1'b1, 1, 1'b1);
        issue(4'b1000, 32'd3, 32'd4, 32'd0, 1'b1, 1, 1'b1);
        drain();

        // Reset in the third cycle of a 20-step SLL aborts it.
        rdy_mode = 0;
`ifdef ALU_SHIFT_EN
        issue(4'b0011, 32'h0000_0001, 32'd20, 32'd0, 1'b0, 20, 1'b0);
`else
        issue(4'b0011, 32'h0000_0001, 32'd20, 32'd0, 1'b1, 1, 1'b1);
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_result", result, 0);
        check("abort_zero", zero, 0);
        check("abort_illegal", illegal, 0);
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_late_valid", seen, 0);
        check("abort_scoreboard_empty", sb_q.size(), 0);

        // Random operations under random backpressure.
        rdy_mode = 2;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            c  = codes[$urandom_range(0, 15)];
            ra = $urandom;
            rb = $urandom;
            model(c, ra, rb, er, ei, el);
            issue(c, ra, rb, er, ei, el, 1'b1);
        end
        rdy_mode = 1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_exec.md
# alu_exec

Multi-cycle ALU execution unit for the single-cycle core's execute stage. It consumes the 4-bit ALU control code produced by the ALU control decoder, together with two operands, under a valid/ready handshake. It returns a registered result plus zero and illegal flags. Logic ops, add, sub and set-less-than complete in one cycle; shifts run iteratively, one bit position per cycle.

## Interface
- XLEN, 32, operand/result width; SHW = $clog2(XLEN) is derived.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operation request.
- in_ready  output  1  unit can accept a request.
- alu_ctrl  input  4  ALU control code.
- a  input  XLEN  operand A.
- b  input  XLEN  operand B; b[SHW-1:0] is the shift amount.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- result  output  XLEN  registered result.
- zero  output  1  result == 0.
- illegal  output  1  unsupported alu_ctrl for this result.

## Operation
- Codes:
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB (a-b); 0111 SLT (signed, result 1 or 0).
  - 0011 SLL; 0100 SRL; 0101 SRA.
  - Any other code is illegal.
- Arithmetic is modulo 2^XLEN. Overflow is ignored, with no flag.
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch alu_ctrl/a/b. A shift with non-zero amount goes to SHIFT; everything else goes to DONE.
  - SHIFT: shift the working register by 1 each cycle and decrement the counter. When the counter reaches 0, go to DONE.
  - DONE: out_valid=1 and result/zero/illegal are held stable. On out_ready, go to IDLE.
- in_ready is high only in IDLE. There is no request overlap.
- Illegal code: result=0, zero=1, illegal=1, same latency as ADD.
- SRA replicates a[XLEN-1] on every step. SRL/SLL fill with 0.
- Inputs are sampled only on the accept cycle. Changes at other times are ignored.

## Timing
- Reset values:
  - state=IDLE, in_ready=1 (first cycle after rst drops).
  - out_valid=0, result=0, zero=0, illegal=0.
- Reset during SHIFT or DONE aborts the operation. The pending result is discarded and no out_valid is produced.
- Latency is counted from the accept edge to the first out_valid cycle:
  - 1 cycle for non-shift, illegal, and shift-by-0.
  - N cycles for a shift by N, where 1 ≤ N ≤ XLEN-1.
- Back-to-back throughput: at best one result every 2 cycles (DONE→IDLE→accept).
- out_valid stays high until out_ready is sampled high. Holding out_ready high continuously is legal.
- out_ready is ignored outside DONE.

## Configuration
- ALU_SHIFT_EN defined:
  - Codes 0011/0100/0101 execute iteratively as specified.
  - The SHIFT state and the shifter are present.
- ALU_SHIFT_EN undefined:
  - The shift codes are treated as illegal (result=0, illegal=1, 1-cycle latency).
  - The SHIFT state and the shifter are not synthesized.

## Structure
- Package alu_pkg holds:
  - localparams for all eight ALU control codes, shared with the ALU control decoder.
  - The state enum (IDLE, SHIFT, DONE).
- Sub-module alu_shifter_iter holds the working register, shift counter and step/done logic. It is instantiated only under ALU_SHIFT_EN.
- The single-cycle datapath (and/or/add/sub/slt) stays inline in alu_exec.

## Test plan
- Reset with out_ready=0, then ADD a=5 b=7 → out_valid one cycle after accept, result=12, zero=0, illegal=0; held until out_ready=1.
- SUB a=9 b=9 → result=0, zero=1. SLT a=0xFFFFFFFF b=1 → result=1.
- SRA a=0x80000000 b=4 → out_valid 4 cycles after accept, result=0xF8000000. SLL b=0 → 1-cycle latency, result=a.
- alu_ctrl=1111 → result=0, illegal=1. Without ALU_SHIFT_EN, SRL gives result=0 and illegal=1 at 1-cycle latency.
- Assert rst in the 3rd cycle of a 20-step SLL → no out_valid, all outputs 0, in_ready=1 on the first cycle after rst drops.
- Random in_valid/out_ready backpressure, 1000 ops → every result matches the golden model; no accept while in_ready=0; result stable while out_valid && !out_ready.
